tug_referee: RTL and testbench
==============================

Name: tug_referee

Overview:
- Game controller for the Tug of War board.
- Turns the two players' raw key levels into single press events and arbitrates presses that land in the same cycle.
- Moves the lit position across the light bar, detects round wins and keeps per-player scores.
- Sits between the key synchronizers and the LED / seven-segment drivers, and sequences each round and the match end.

Parameters:
NUM_LIGHTS, 9, number of LEDs in the bar; odd, >=3; centre index = NUM_LIGHTS/2
SCORE_W, 3, width of each score counter
MATCH_POINTS, 7, round wins that end the match; 1..2^SCORE_W-1
HOLD_CYCLES, 8, cycles the win display is held before the next round; >=1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
key_l  input  1  left player key level, already synchronized, active-high
key_r  input  1  right player key level, already synchronized, active-high
lights  output  NUM_LIGHTS  one-hot light position; bit NUM_LIGHTS-1 is leftmost; all-zero when no position is shown
winner  output  2  00 none, 01 right, 10 left; 11 never driven
score_l  output  SCORE_W  left round wins
score_r  output  SCORE_W  right round wins
game_over  output  1  high while in MATCH_OVER

Behaviour:
- Clock and reset: clk, rising edge. reset is synchronous and active-high; it overrides all other activity.
- Reset values:
  - state PLAY, pos = centre, so lights = one-hot centre.
  - winner 00, score_l 0, score_r 0, game_over 0, hold counter 0.
  - Edge-detector history registers reset to 1, so a key held through reset is not a press.
- Press detection:
  - press_x is registered: it is high for exactly one cycle, the cycle after the first edge at which key_x is sampled 1 following a sample of 0.
  - Light movement occurs on the next edge. Latency from key sampled high to lights change = 2 edges.
  - A held key produces one press only.
  - Detectors run in every state, so a key held through WIN_HOLD does not fire on return to PLAY.
- Arbitration: press_l and press_r in the same cycle cancel. No move, no score change.
- PLAY state:
  - press_l alone with pos < NUM_LIGHTS-1: pos+1.
  - press_r alone with pos > 0: pos-1.
  - press_l alone with pos = NUM_LIGHTS-1 (left wins):
    - score_l+1 and winner = 10.
    - lights all-zero.
    - If the new score_l = MATCH_POINTS, go to MATCH_OVER.
    - Otherwise go to WIN_HOLD with hold counter = HOLD_CYCLES-1.
  - press_r alone with pos = 0: symmetric, with score_r and winner = 01.
- WIN_HOLD state:
  - Presses are ignored; lights all-zero; winner is held.
  - Each edge decrements the hold counter.
  - At the edge where the counter is 0: go to PLAY, pos = centre, winner = 00.
  - WIN_HOLD therefore lasts exactly HOLD_CYCLES cycles.
- MATCH_OVER state:
  - lights all-zero; winner and scores held; game_over = 1.
  - Presses are ignored. Only reset exits.
- Scores never exceed MATCH_POINTS, so no wrap is possible.
- Reset mid-round or mid-hold returns everything to the reset values on that edge.
- All outputs are registered or decoded directly from registered state; there is no combinational path from key inputs to outputs.

Decomposition:
- Package tug_pkg contains:
  - typedef enum state_t {PLAY, WIN_HOLD, MATCH_OVER};
  - winner encoding constants WIN_NONE=2'b00, WIN_RIGHT=2'b01, WIN_LEFT=2'b10.
- Sub-module press_pulse (clk, reset, key, press): registered rising-edge detector with history reset to 1. Instantiated twice.
- The FSM, position counter, hold counter and score counters live in tug_referee.

Test Plan:
All scenarios use NUM_LIGHTS=5, MATCH_POINTS=2, HOLD_CYCLES=4; centre lights = 00100.
1. Reset for 2 cycles -> lights 00100, winner 00, score_l 0, score_r 0, game_over 0.
2. key_l held high for 10 cycles from centre -> lights 01000 two edges after the first high sample, then no further change. key_r pulse 1 cycle -> lights back to 00100.
3. key_l and key_r rise in the same cycle -> lights stay 00100 for the following 5 cycles, scores unchanged.
4. Three separate key_l presses from centre -> 01000, 10000, then lights 00000, winner 10, score_l 1. Extra key_r press during the hold -> ignored. After 4 cycles -> lights 00100, winner 00.
5. Right wins two rounds (three key_r presses each) -> after the second win, score_r 2, winner 01, game_over 1, lights 00000. Further presses for 20 cycles -> no change. Reset -> all outputs return to reset values.
6. Reset asserted mid-WIN_HOLD with key_r held high through and after reset -> lights 00100, scores 0, and no move while key_r stays high. Releasing and re-pressing key_r -> lights 00010.

Source files
------------

// File: rtl/tug_pkg.sv
// ============================================================================
// Module   : tug_pkg
// Purpose  : Shared state and winner encodings for the Tug of War referee.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tug_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    WIN_HOLD   = 2'd1,
    MATCH_OVER = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RIGHT = 2'b01;
  localparam logic [1:0] WIN_LEFT  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/press_pulse.sv
// ============================================================================
// Module   : press_pulse
// Purpose  : Registered rising-edge detector; one-cycle press per key press.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module press_pulse (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  logic hist_q;
  logic press_q;

  // History resets high so a key already held at reset never counts as a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      hist_q  <= key;
      press_q <= key & ~hist_q;
    end
  end

  assign press = press_q;

endmodule

`default_nettype wire

// File: rtl/tug_referee.sv
// ============================================================================
// Module   : tug_referee
// Purpose  : Tug of War game controller: press arbitration, light position,
//            round wins, scores and match sequencing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tug_referee
  import tug_pkg::*;
#(
  parameter int NUM_LIGHTS   = 9,
  parameter int SCORE_W      = 3,
  parameter int MATCH_POINTS = 7,
  parameter int HOLD_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_l,
  input  logic                  key_r,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [1:0]            winner,
  output logic [SCORE_W-1:0]    score_l,
  output logic [SCORE_W-1:0]    score_r,
  output logic                  game_over
);

  localparam int POS_W  = $clog2(NUM_LIGHTS);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [POS_W-1:0]      C_POS_CENTRE = POS_W'(NUM_LIGHTS / 2);
  localparam logic [POS_W-1:0]      C_POS_MAX    = POS_W'(NUM_LIGHTS - 1);
  localparam logic [HOLD_W-1:0]     C_HOLD_INIT  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0]    C_MATCH_SCORE = SCORE_W'(MATCH_POINTS);
  localparam logic [NUM_LIGHTS-1:0] C_ONE_LIGHT  = NUM_LIGHTS'(1);

  logic press_l;
  logic press_r;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SCORE_W-1:0]  score_l_q, score_l_d;
  logic [SCORE_W-1:0]  score_r_q, score_r_d;
  logic [1:0]          winner_q, winner_d;

  press_pulse u_press_l (
    .clk   (clk),
    .reset (reset),
    .key   (key_l),
    .press (press_l)
  );

  press_pulse u_press_r (
    .clk   (clk),
    .reset (reset),
    .key   (key_r),
    .press (press_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= PLAY;
      pos_q     <= C_POS_CENTRE;
      hold_q    <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      winner_q  <= WIN_NONE;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      hold_q    <= hold_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    hold_d    = hold_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;

    case (state_q)
      PLAY: begin
        // Simultaneous presses cancel, so only a lone press acts.
        if (press_l && !press_r) begin
          if (pos_q == C_POS_MAX) begin
            score_l_d = score_l_q + 1'b1;
            winner_d  = WIN_LEFT;
            if (score_l_d == C_MATCH_SCORE) begin
              state_d = MATCH_OVER;
            end else begin
              state_d = WIN_HOLD;
              hold_d  = C_HOLD_INIT;
            end
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end else if (press_r && !press_l) begin
          if (pos_q == '0) begin
            score_r_d = score_r_q + 1'b1;
            winner_d  = WIN_RIGHT;
            if (score_r_d == C_MATCH_SCORE) begin
              state_d = MATCH_OVER;
            end else begin
              state_d = WIN_HOLD;
              hold_d  = C_HOLD_INIT;
            end
          end else begin
            pos_d = pos_q - 1'b1;
          end
        end
      end
      WIN_HOLD: begin
        if (hold_q == '0) begin
          state_d  = PLAY;
          pos_d    = C_POS_CENTRE;
          winner_d = WIN_NONE;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      MATCH_OVER: begin
      end
      default: begin
        state_d = PLAY;
      end
    endcase
  end

  assign lights    = (state_q == PLAY) ? (C_ONE_LIGHT << pos_q) : '0;
  assign winner    = winner_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign game_over = (state_q == MATCH_OVER);

endmodule

`default_nettype wire

// File: tb/tb_tug_referee.sv
// ============================================================================
// Module   : tb_tug_referee
// Purpose  : Scoreboard bench for tug_referee: directed rounds plus random keys.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tug_referee;

  localparam int NL = 5;
  localparam int SW = 3;
  localparam int MP = 2;
  localparam int HC = 4;
  localparam int CENTRE = NL / 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          key_l = 1'b0;
  logic          key_r = 1'b0;
  logic [NL-1:0] lights;
  logic [1:0]    winner;
  logic [SW-1:0] score_l;
  logic [SW-1:0] score_r;
  logic          game_over;

  tug_referee #(
    .NUM_LIGHTS   (NL),
    .SCORE_W      (SW),
    .MATCH_POINTS (MP),
    .HOLD_CYCLES  (HC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_l     (key_l),
    .key_r     (key_r),
    .lights    (lights),
    .winner    (winner),
    .score_l   (score_l),
    .score_r   (score_r),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NL-1:0] lights;
    logic [1:0]    winner;
    logic [SW-1:0] score_l;
    logic [SW-1:0] score_r;
    logic          game_over;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 1'b0;

  // Reference model: rope offset from centre (positive = toward left end),
  // remaining celebration cycles, match-over flag and pending key presses.
  int off = 0;
  int hold_left = 0;
  bit over = 1'b0;
  int m_sl = 0;
  int m_sr = 0;
  int m_win = 0;
  bit prev_l = 1'b1;
  bit prev_r = 1'b1;
  bit pend_l = 1'b0;
  bit pend_r = 1'b0;

  task automatic model_edge(input bit kl, input bit kr, input bit rst);
    if (rst) begin
      off = 0; hold_left = 0; over = 1'b0;
      m_sl = 0; m_sr = 0; m_win = 0;
      prev_l = 1'b1; prev_r = 1'b1; pend_l = 1'b0; pend_r = 1'b0;
    end else begin
      if (over) begin
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) begin
          off = 0;
          m_win = 0;
        end
      end else if (pend_l && !pend_r) begin
        if (off == CENTRE) begin
          m_sl++;
          m_win = 2;
          if (m_sl == MP) over = 1'b1;
          else hold_left = HC;
        end else begin
          off++;
        end
      end else if (pend_r && !pend_l) begin
        if (off == -CENTRE) begin
          m_sr++;
          m_win = 1;
          if (m_sr == MP) over = 1'b1;
          else hold_left = HC;
        end else begin
          off--;
        end
      end
      pend_l = kl && !prev_l;
      pend_r = kr && !prev_r;
      prev_l = kl;
      prev_r = kr;
    end
  endtask

  task automatic drive(input bit kl, input bit kr, input bit rst);
    exp_t e;
    @(negedge clk);
    key_l = kl;
    key_r = kr;
    reset = rst;
    model_edge(kl, kr, rst);
    e.lights    = (over || hold_left > 0) ? '0 : NL'(1 << (CENTRE + off));
    e.winner    = 2'(m_win);
    e.score_l   = SW'(m_sl);
    e.score_r   = SW'(m_sr);
    e.game_over = over;
    exp_q.push_back(e);
  endtask

  task automatic repeat_drive(input bit kl, input bit kr, input bit rst, input int n);
    for (int i = 0; i < n; i++) drive(kl, kr, rst);
  endtask

  task automatic tap_l();
    drive(1'b1, 1'b0, 1'b0);
    repeat_drive(1'b0, 1'b0, 1'b0, 2);
  endtask

  task automatic tap_r();
    drive(1'b0, 1'b1, 1'b0);
    repeat_drive(1'b0, 1'b0, 1'b0, 2);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lights",    int'(lights),    int'(e.lights));
      chk("winner",    int'(winner),    int'(e.winner));
      chk("score_l",   int'(score_l),   int'(e.score_l));
      chk("score_r",   int'(score_r),   int'(e.score_r));
      chk("game_over", int'(game_over), int'(e.game_over));
    end else if (done) begin
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bit cl, cr;
    // Reset state
    repeat_drive(1'b0, 1'b0, 1'b1, 2);
    // Held key moves once; a short right tap returns to centre
    repeat_drive(1'b1, 1'b0, 1'b0, 10);
    repeat_drive(1'b0, 1'b0, 1'b0, 2);
    tap_r();
    repeat_drive(1'b0, 1'b0, 1'b0, 2);
    // Simultaneous presses cancel
    repeat_drive(1'b1, 1'b1, 1'b0, 6);
    repeat_drive(1'b0, 1'b0, 1'b0, 2);
    // Left wins a round; right press during the hold is ignored
    tap_l(); tap_l(); tap_l();
    drive(1'b0, 1'b1, 1'b0);
    repeat_drive(1'b0, 1'b0, 1'b0, 6);
    // Right wins the match, then presses are ignored until reset
    repeat_drive(1'b0, 1'b0, 1'b1, 2);
    for (int r = 0; r < 2; r++) begin
      tap_r(); tap_r(); tap_r();
      repeat_drive(1'b0, 1'b0, 1'b0, 6);
    end
    for (int i = 0; i < 20; i++) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    repeat_drive(1'b0, 1'b0, 1'b1, 2);
    repeat_drive(1'b0, 1'b0, 1'b0, 2);
    // Reset mid-hold with right key held through and after reset
    tap_l(); tap_l(); tap_l();
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    repeat_drive(1'b0, 1'b1, 1'b0, 5);
    drive(1'b0, 1'b0, 1'b0);
    tap_r();
    repeat_drive(1'b0, 1'b0, 1'b0, 2);
    // Random key activity with occasional reset
    cl = 1'b0;
    cr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) cl = ~cl;
      if ($urandom_range(0, 3) == 0) cr = ~cr;
      drive(cl, cr, ($urandom_range(0, 79) == 0));
    end
    repeat_drive(1'b0, 1'b0, 1'b0, 2);
    done = 1'b1;
  end

endmodule

`default_nettype wire
